// File: rtl/bioz_siggen_ram_sequencer_if.sv
// bioz_siggen_ram_sequencer_if
// Groups the waveform-load stream and the DAC sample output of the BioZ
// signal-generator RAM sequencer.
//   load_data / load_valid : table word stream into the sequencer
//   load_ready             : sequencer accepts a word this cycle (LOAD only)
//   load_done              : one-cycle pulse after the last table word is written
//   dac_code / dac_valid   : registered DAC sample (offset binary) and its strobe
//   wrap                   : pulses with dac_valid for the last table entry
// Modports: master = stream source / DAC consumer, slave = sequencer.
interface bioz_siggen_ram_sequencer_if #(
    parameter int DATA_WIDTH = 12
) ();
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_valid;
    logic                  load_ready;
    logic                  load_done;
    logic [DATA_WIDTH-1:0] dac_code;
    logic                  dac_valid;
    logic                  wrap;

    modport master (
        output load_data, load_valid,
        input  load_ready, load_done, dac_code, dac_valid, wrap
    );

    modport slave (
        input  load_data, load_valid,
        output load_ready, load_done, dac_code, dac_valid, wrap
    );
endinterface

// File: rtl/bioz_siggen_ram_sequencer.sv
// bioz_siggen_ram_sequencer
// Controller in front of the BioZ signal-generator single-port RAM. In LOAD it
// writes a waveform table arriving on a valid/ready stream; in PLAY it reads
// the table back cyclically, one sample every per_q+1 clocks, and presents
// each sample to the excitation DAC with a one-cycle strobe. Stopping always
// leaves the DAC at midscale so the electrode never sits at a DC offset.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   sig (slave)  : load stream (load_data/valid/ready/done) and DAC output
//                  (dac_code/dac_valid/wrap)
//   load_start   : pulse, abort everything and start a table load
//   play_en      : level, run playback while high
//   len          : last table index, sampled on LOAD/PLAY entry
//   div          : sample period minus 1 (clamped to >= 2), sampled on PLAY entry
//   ram_*        : RAM address, cs/we/oe and shared bidirectional data bus
//   busy         : high in any state except IDLE
//
// Optional feature, macro BIOZ_SIGGEN_INVERT_EN: adds input 'invert' (sampled
// on PLAY entry); when set, samples are output as (2^DATA_WIDTH-1) - sample.
// Midscale output is unaffected.
module bioz_siggen_ram_sequencer #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    bioz_siggen_ram_sequencer_if.slave    sig,
    input  logic                          load_start,
    input  logic                          play_en,
    input  logic [ADDR_WIDTH-1:0]         len,
    input  logic [DIV_WIDTH-1:0]          div,
`ifdef BIOZ_SIGGEN_INVERT_EN
    input  logic                          invert,
`endif
    output logic [ADDR_WIDTH-1:0]         ram_address,
    output logic                          ram_cs,
    output logic                          ram_we,
    output logic                          ram_oe,
    inout  wire  [DATA_WIDTH-1:0]         ram_data,
    output logic                          busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RD_WAIT,
        RD_ADDR,
        RD_CAP,
        STOP
    } state_t;

    localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DIV_WIDTH-1:0]  MIN_PER  = DIV_WIDTH'(2);

    state_t                 state_q, state_d;
    logic                   stop_pend_q, stop_pend_d;
    logic [ADDR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q, len_q;
    logic [DIV_WIDTH-1:0]   per_q, tick_q;
    logic [DATA_WIDTH-1:0]  dac_code_q;
    logic                   dac_valid_q, wrap_q, load_done_q;
    logic [DATA_WIDTH-1:0]  sample;
    logic                   wr_en, cap_en, mid_en, play_init, load_init, playing;

`ifdef BIOZ_SIGGEN_INVERT_EN
    logic invert_q;
    assign sample = invert_q ? ~ram_data : ram_data;
`else
    assign sample = ram_data;
`endif

    // The controller only drives the shared bus while writing; during reads
    // the RAM owns it.
    assign ram_data = ram_we ? sig.load_data : {DATA_WIDTH{1'bz}};

    assign playing        = (state_q == RD_WAIT) || (state_q == RD_ADDR) || (state_q == RD_CAP);
    assign busy           = (state_q != IDLE);
    assign sig.load_ready = (state_q == LOAD) && !load_start;
    assign sig.load_done  = load_done_q;
    assign sig.dac_code   = dac_code_q;
    assign sig.dac_valid  = dac_valid_q;
    assign sig.wrap       = wrap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_oe      = 1'b0;
        ram_address = '0;
        wr_en       = 1'b0;
        cap_en      = 1'b0;
        mid_en      = 1'b0;
        play_init   = 1'b0;
        load_init   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (play_en) begin
                    state_d   = RD_ADDR;
                    play_init = 1'b1;
                end
            end
            LOAD: begin
                if (sig.load_valid) begin
                    ram_cs      = 1'b1;
                    ram_we      = 1'b1;
                    ram_address = wr_ptr_q;
                    wr_en       = 1'b1;
                    if (wr_ptr_q == len_q) begin
                        state_d = IDLE;
                    end
                end
            end
            RD_ADDR: begin
                ram_cs      = 1'b1;
                ram_oe      = 1'b1;
                ram_address = rd_ptr_q;
                state_d     = RD_CAP;
                // The read already issued must still reach the DAC, so a
                // drop of play_en here is remembered until after the capture.
                stop_pend_d = !play_en;
            end
            RD_CAP: begin
                ram_cs      = 1'b1;
                ram_oe      = 1'b1;
                ram_address = rd_ptr_q;
                cap_en      = 1'b1;
                state_d     = (!play_en || stop_pend_q) ? STOP : RD_WAIT;
            end
            RD_WAIT: begin
                if (!play_en) begin
                    state_d = STOP;
                end else if (tick_q == per_q) begin
                    state_d = RD_ADDR;
                end
            end
            STOP: begin
                mid_en  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // load_start overrides everything; an interrupted playback still
        // returns the DAC to midscale in this same cycle.
        if (load_start) begin
            state_d     = LOAD;
            load_init   = 1'b1;
            play_init   = 1'b0;
            wr_en       = 1'b0;
            cap_en      = 1'b0;
            mid_en      = playing || (state_q == STOP);
            ram_cs      = 1'b0;
            ram_we      = 1'b0;
            ram_oe      = 1'b0;
            ram_address = '0;
        end
    end

    // NOTE: the table lives in the external RAM; reset clears only the
    // controller's own registers and leaves the RAM contents intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            len_q       <= '0;
            per_q       <= MIN_PER;
            tick_q      <= '0;
            dac_code_q  <= MIDSCALE;
            dac_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            load_done_q <= 1'b0;
`ifdef BIOZ_SIGGEN_INVERT_EN
            invert_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here sees the pre-edge values of the others.
            dac_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            load_done_q <= 1'b0;

            if (load_init) begin
                wr_ptr_q <= '0;
                len_q    <= len;
            end

            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (wr_ptr_q == len_q) begin
                    load_done_q <= 1'b1;
                end
            end

            if (play_init) begin
                rd_ptr_q <= '0;
                tick_q   <= '0;
                len_q    <= len;
                per_q    <= (div < MIN_PER) ? MIN_PER : div;
`ifdef BIOZ_SIGGEN_INVERT_EN
                invert_q <= invert;
`endif
            end else if (playing) begin
                // One read is issued each time the tick counter wraps.
                tick_q <= (tick_q == per_q) ? '0 : tick_q + 1'b1;
            end

            if (cap_en) begin
                dac_code_q  <= sample;
                dac_valid_q <= 1'b1;
                wrap_q      <= (rd_ptr_q == len_q);
                rd_ptr_q    <= (rd_ptr_q == len_q) ? '0 : rd_ptr_q + 1'b1;
            end

            if (mid_en) begin
                dac_code_q  <= MIDSCALE;
                dac_valid_q <= 1'b1;
            end
        end
    end

endmodule
